// File: rtl/sub_64_seq.sv
// sub_64_seq: multi-cycle subtractor computing in1 - in2 - bin one CHUNK-bit
// slice per clock. The borrow between slices is carried in a register, so
// the critical path is a single CHUNK-bit subtract plus the borrow select.
// A start/busy/done handshake accepts one operation at a time. All outputs
// are driven straight from flops.

module sub_64_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so a single-chunk build still elaborates.
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Registered state and its next-state values.
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             brw_q,    brw_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Slice datapath for the chunk currently selected by cnt_q.
    logic [31:0]      sh_s;
    logic [CHUNK-1:0] ca_s;
    logic [CHUNK-1:0] cb_s;
    logic [CHUNK:0]   csub_s;
    logic [CHUNK-1:0] cd_s;
    logic             cbo_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] ins_s;
    logic             ovf_s;

    // Slice subtract: pick chunk cnt_q of both operands, subtract with the
    // held borrow on CHUNK+1 bits, and prepare the merged diff word.
    always_comb begin
        sh_s   = 32'(cnt_q) * 32'(CHUNK);
        ca_s   = CHUNK'(a_q >> sh_s);
        cb_s   = CHUNK'(b_q >> sh_s);
        csub_s = {1'b0, ca_s} - {1'b0, cb_s} - {{CHUNK{1'b0}}, brw_q};
        cd_s   = csub_s[CHUNK-1:0];
        cbo_s  = csub_s[CHUNK];
        mask_s = {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << sh_s;
        ins_s  = {{(WIDTH-CHUNK){1'b0}}, cd_s} << sh_s;
        // On the last slice cd_s carries the result MSB; signed overflow
        // happens when the operand signs differ and the result sign
        // disagrees with the minuend.
        ovf_s  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ cd_s[CHUNK-1]);
    end

    // Next-state logic for the IDLE/RUN controller and the result registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Capture operands; diff is overwritten slice by slice
                    // so it is left alone here.
                    a_d     = in1;
                    b_d     = in2;
                    brw_d   = bin;
                    cnt_d   = {CW{1'b0}};
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                diff_d = (diff_q & ~mask_s) | ins_s;
                brw_d  = cbo_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    bout_d  = cbo_s;
                    ovf_d   = ovf_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset that also aborts a running operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_64_seq.sv
// Testbench for sub_64_seq: directed and random operations checked against a
// wide-arithmetic reference model, plus handshake and mid-operation reset.

module tb_sub_64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        bin;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    sub_64_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: plain unsigned and signed arithmetic on wider words.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic c,
                                  output logic [63:0] d, output logic bo, output logic ov);
        logic        [64:0] u;
        logic signed [65:0] s;
        u  = {1'b0, a} - {1'b0, b} - {64'd0, c};
        d  = u[63:0];
        bo = ({1'b0, a} < ({1'b0, b} + {64'd0, c}));
        s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, c});
        ov = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from idle, with inputs scrambled after capture.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        int          lat;
        model(a, b, c, ed, eb, eo);
        in1 = a; in2 = b; bin = c; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":busy_after_start"}, 64'(busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            in1 = rnd64(); in2 = rnd64(); bin = 1'($urandom_range(0, 1));
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ":latency"}, 64'(lat), 64'd4);
        chk({tag, ":diff"}, diff, ed);
        chk({tag, ":bout"}, 64'(bout), 64'(eb));
        chk({tag, ":ovf"}, 64'(ovf), 64'(eo));
        chk({tag, ":busy_at_done"}, 64'(busy), 64'd0);
        tick();
        chk({tag, ":done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, ":diff_hold"}, diff, ed);
    endtask

    initial begin
        logic [63:0] ea, eb64, ed;
        logic        ebo, eov;
        int          ndone, e, lat;
        int          dq[$];

        rst = 1'b1; start = 1'b0; in1 = 64'd0; in2 = 64'd0; bin = 1'b0;
        #12;
        chk("reset:busy", 64'(busy), 64'd0);
        chk("reset:done", 64'(done), 64'd0);
        chk("reset:diff", diff, 64'd0);
        chk("reset:bout", 64'(bout), 64'd0);
        chk("reset:ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_op("basic", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0);
        chk("basic:diff_const", diff, 64'h0000_0000_0000_0002);
        run_op("xchunk", 64'h0000_0001_0000_0000, 64'h1, 1'b0);
        chk("xchunk:diff_const", diff, 64'h0000_0000_FFFF_FFFF);
        run_op("underflow", 64'h0, 64'h0, 1'b1);
        chk("underflow:diff_const", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("underflow:bout_const", 64'(bout), 64'd1);
        run_op("sovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0);
        chk("sovf:diff_const", diff, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sovf:ovf_const", 64'(ovf), 64'd1);
        run_op("sovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("equal_bin", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);

        // Random operations, some with related operands to stress borrows.
        for (int i = 0; i < 24; i++) begin
            ea   = rnd64();
            eb64 = (i % 4 == 0) ? ea : ((i % 4 == 1) ? (ea + 64'(1)) : rnd64());
            run_op("random", ea, eb64, 1'($urandom_range(0, 1)));
        end

        // Second start two cycles into an operation must be ignored.
        ea = rnd64(); eb64 = rnd64();
        model(ea, eb64, 1'b0, ed, ebo, eov);
        in1 = ea; in2 = eb64; bin = 1'b0; start = 1'b1;
        tick();
        e = 0;
        start = 1'b0;
        tick(); e++;
        in1 = rnd64(); in2 = rnd64(); bin = 1'b1; start = 1'b1;
        tick(); e++;
        start = 1'b0;
        ndone = 0; lat = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); e++;
            if (done) begin
                ndone++;
                lat = e;
                chk("ignore:diff", diff, ed);
                chk("ignore:bout", 64'(bout), 64'(ebo));
                chk("ignore:ovf", 64'(ovf), 64'(eov));
            end
        end
        chk("ignore:done_count", 64'(ndone), 64'd1);
        chk("ignore:latency", 64'(lat), 64'd4);

        // Start held high: one done every NCH+1 cycles.
        ea = rnd64(); eb64 = rnd64();
        model(ea, eb64, 1'b1, ed, ebo, eov);
        in1 = ea; in2 = eb64; bin = 1'b1; start = 1'b1;
        tick();
        e = 0;
        for (int i = 0; i < 16; i++) begin
            tick(); e++;
            if (done) begin
                dq.push_back(e);
                chk("held:diff", diff, ed);
                chk("held:bout", 64'(bout), 64'(ebo));
            end
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("held:done_count", 64'(dq.size()), 64'd3);
        if (dq.size() == 3) begin
            chk("held:first", 64'(dq[0]), 64'd4);
            chk("held:gap1", 64'(dq[1] - dq[0]), 64'd5);
            chk("held:gap2", 64'(dq[2] - dq[1]), 64'd5);
        end
        chk("held:idle_after", 64'(busy), 64'd0);

        // Asynchronous reset two cycles into an operation.
        in1 = rnd64(); in2 = rnd64(); bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("rstmid:busy", 64'(busy), 64'd0);
        chk("rstmid:done", 64'(done), 64'd0);
        chk("rstmid:diff", diff, 64'd0);
        chk("rstmid:bout", 64'(bout), 64'd0);
        chk("rstmid:ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("rstmid:no_done", 64'(ndone), 64'd0);
        run_op("after_rst", rnd64(), rnd64(), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
